// File: rtl/mode_stepper.sv
// Pushbutton mode sequencer: synchronised, debounced enter/back keys step a wrapping mode index;
// switches drive a priority one-hot LED bus. Define MODE_STEPPER_AUTO_EN for timed auto-advance.
module mode_stepper #(
    parameter int NUM_MODES       = 7,
    parameter int MODE_W          = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SW_W            = 10,
    parameter int LED_W           = 8,
    parameter int AUTO_CYCLES     = 50000000
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              enter_bar,
    input  logic              back_bar,
    input  logic [SW_W-1:0]   sw,
`ifdef MODE_STEPPER_AUTO_EN
    input  logic              auto_en,
`endif
    output logic [MODE_W-1:0] mode,
    output logic              mode_chg,
    output logic [LED_W-1:0]  led
);

    localparam int                DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

    logic [1:0]        w_key_raw;
    logic [1:0]        w_press;
    logic              w_enter_evt;
    logic              w_back_evt;
    logic              w_key_evt;
    logic              w_auto_step;
    logic [MODE_W-1:0] w_mode_up;
    logic [MODE_W-1:0] w_mode_down;
    logic [LED_W-1:0]  w_led_next;
    logic              w_unused_sw;

    logic [MODE_W-1:0] r_mode;
    logic              r_mode_chg;
    logic [LED_W-1:0]  r_led;

    assign w_key_raw = {back_bar, enter_bar};

    // Bit 0 is enter, bit 1 is back; each gets its own synchroniser and debouncer.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic            r_sync1;
            logic            r_sync2;
            logic            r_deb;
            logic            r_press;
            logic [DB_W-1:0] r_cnt;

            always_ff @(posedge clk_50M or posedge rst) begin
                if (rst) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                    r_deb   <= 1'b1;
                    r_press <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_key_raw[gi];
                    r_sync2 <= r_sync1;
                    r_press <= 1'b0;
                    if (r_sync2 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        // Accept the new level; only the falling edge is a press.
                        r_deb   <= r_sync2;
                        r_cnt   <= '0;
                        r_press <= ~r_sync2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    assign w_enter_evt = w_press[0] & ~w_press[1];
    assign w_back_evt  = w_press[1] & ~w_press[0];
    assign w_key_evt   = |w_press;

`ifdef MODE_STEPPER_AUTO_EN
    localparam int              AC_W    = $clog2(AUTO_CYCLES + 1);
    localparam logic [AC_W-1:0] AC_LAST = AC_W'(AUTO_CYCLES - 1);

    logic [AC_W-1:0] r_auto_cnt;

    // Any key activity restarts the interval, so a key event always wins over an auto step.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_auto_cnt <= '0;
        end else if (w_key_evt || !auto_en) begin
            r_auto_cnt <= '0;
        end else if (r_auto_cnt == AC_LAST) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + 1'b1;
        end
    end

    assign w_auto_step = auto_en && !w_key_evt && (r_auto_cnt == AC_LAST);
`else
    assign w_auto_step = 1'b0;
`endif

    assign w_mode_up   = (r_mode == MODE_LAST) ? '0 : r_mode + 1'b1;
    assign w_mode_down = (r_mode == '0) ? MODE_LAST : r_mode - 1'b1;

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_mode     <= '0;
            r_mode_chg <= 1'b0;
        end else begin
            r_mode_chg <= 1'b0;
            if (w_enter_evt || w_auto_step) begin
                r_mode     <= w_mode_up;
                r_mode_chg <= 1'b1;
            end else if (w_back_evt) begin
                r_mode     <= w_mode_down;
                r_mode_chg <= 1'b1;
            end
        end
    end

    // Ascending scan: the highest set bit is written last and wins.
    always_comb begin
        w_led_next = '0;
        for (int i = 0; i < LED_W; i++) begin
            if (sw[i]) begin
                w_led_next    = '0;
                w_led_next[i] = 1'b1;
            end
        end
    end

    assign w_unused_sw = ^sw;

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_next;
        end
    end

    assign mode     = r_mode;
    assign mode_chg = r_mode_chg;
    assign led      = r_led;

endmodule
